cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- Operands are split into CHUNK-bit slices. Each pipeline stage resolves one slice and registers the carry into the next stage.
- Valid/ready handshake on both sides, so it drops into the ALU datapath of the multi-cycle processor and into streaming arithmetic units.
- Adds subtract mode, carry-in, and signed-overflow and zero flags.

---
 rtl/cla_pkg.sv | 14 +
 rtl/cla_group4.sv | 31 +++
 rtl/cla_pipe_adder.sv | 127 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and parameter helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  function automatic int unsigned cla_stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

  function automatic bit cla_params_ok(input int unsigned width, input int unsigned chunk);
    return (width != 0) && (chunk != 0) && (width % chunk == 0) && (chunk % GROUP_W == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group with group propagate/generate.
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               cout,
  output logic               gp,
  output logic               gg
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;
  assign cout = gg | (gp & cin);
  assign sum  = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one CHUNK-bit slice resolved per stage,
// operands skewed forward and partial sums de-skewed, valid/ready on both sides.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CHUNK  = 8,
  parameter int unsigned STAGES = cla_stages(WIDTH, CHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned NG = CHUNK / GROUP_W;

  if (!cla_params_ok(WIDTH, CHUNK) || (STAGES != cla_stages(WIDTH, CHUNK))) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of CHUNK, CHUNK a multiple of 4, STAGES derived");
  end

  // Whole pipeline moves in lockstep; bubbles travel like data.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM = WIDTH - k * CHUNK;
    localparam int unsigned LOW = k * CHUNK;

    logic [REM-1:0]       a_cur;
    logic [REM-1:0]       b_cur;
    logic                 c_cur;
    logic                 v_cur;
    logic [CHUNK-1:0]     s_slice;
    logic [LOW+CHUNK-1:0] s_acc;
    logic [NG:0]          gc;
    logic [NG-1:0]        gp;
    logic [NG-1:0]        gg;
    logic [NG-1:0]        cout_unused;

    // Stage 0 prepares operands; later stages read the previous skew registers.
    if (k == 0) begin : g_src
      assign a_cur = in_a;
      assign b_cur = in_b ^ {WIDTH{in_sub}};
      assign c_cur = in_sub | in_cin;
      assign v_cur = in_valid;
      assign s_acc = s_slice;
    end else begin : g_src
      assign a_cur = g_stage[k-1].g_fwd.a_q;
      assign b_cur = g_stage[k-1].g_fwd.b_q;
      assign c_cur = g_stage[k-1].g_fwd.c_q;
      assign v_cur = g_stage[k-1].g_fwd.v_q;
      assign s_acc = {s_slice, g_stage[k-1].g_fwd.s_q};
    end

    // Group-to-group lookahead across the slice.
    assign gc[0] = c_cur;
    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group4 u_grp (
        .a    (a_cur[j*GROUP_W +: GROUP_W]),
        .b    (b_cur[j*GROUP_W +: GROUP_W]),
        .cin  (gc[j]),
        .sum  (s_slice[j*GROUP_W +: GROUP_W]),
        .cout (cout_unused[j]),
        .gp   (gp[j]),
        .gg   (gg[j])
      );
      assign gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;
      logic                 c_q;
      logic                 v_q;
      logic [LOW+CHUNK-1:0] s_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
          s_q <= '0;
        end else if (adv) begin
          a_q <= a_cur[REM-1:CHUNK];
          b_q <= b_cur[REM-1:CHUNK];
          c_q <= gc[NG];
          v_q <= v_cur;
          s_q <= s_acc;
        end
      end
    end else begin : g_out
      // Carry into the MSB recovered from sum = a ^ b ^ c.
      logic c_msb;
      assign c_msb = s_slice[CHUNK-1] ^ a_cur[REM-1] ^ b_cur[REM-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_sum   <= '0;
          out_cout  <= 1'b0;
          out_ovf   <= 1'b0;
          out_zero  <= 1'b0;
        end else if (adv) begin
          out_valid <= v_cur;
          out_sum   <= s_acc;
          out_cout  <= gc[NG];
          out_ovf   <= c_msb ^ gc[NG];
          out_zero  <= ~|s_acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized checks of the pipelined CLA adder at three geometries.
module tb_cla_pipe_adder;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 4;
  localparam int unsigned NSW = 1500;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf, out_zero;

  logic         s8_valid = 1'b0, s8_ready, s8_cin = 1'b0, s8_sub = 1'b0;
  logic [7:0]   s8_a = '0, s8_b = '0, s8_sum;
  logic         s8_ovalid, s8_cout, s8_ovf, s8_zero;

  logic         s16_valid = 1'b0, s16_ready, s16_cin = 1'b0, s16_sub = 1'b0;
  logic [15:0]  s16_a = '0, s16_b = '0, s16_sum;
  logic         s16_ovalid, s16_cout, s16_ovf, s16_zero;

  int unsigned  nchk = 0;
  int unsigned  npass = 0;
  logic [63:0]  q32[$];
  logic [63:0]  q8[$];
  logic [63:0]  q16[$];
  logic [63:0]  exp0;
  int unsigned  ngot;

  always #5 clk = ~clk;

  cla_pipe_adder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  cla_pipe_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s8_valid), .in_ready(s8_ready),
    .in_a(s8_a), .in_b(s8_b), .in_cin(s8_cin), .in_sub(s8_sub),
    .out_valid(s8_ovalid), .out_ready(1'b1), .out_sum(s8_sum),
    .out_cout(s8_cout), .out_ovf(s8_ovf), .out_zero(s8_zero)
  );

  cla_pipe_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s16_valid), .in_ready(s16_ready),
    .in_a(s16_a), .in_b(s16_b), .in_cin(s16_cin), .in_sub(s16_sub),
    .out_valid(s16_ovalid), .out_ready(1'b1), .out_sum(s16_sum),
    .out_cout(s16_cout), .out_ovf(s16_ovf), .out_zero(s16_zero)
  );

  // Reference: plain integer arithmetic, packed as {cout, ovf, zero, sum[31:0]}.
  function automatic logic [63:0] model(input int unsigned w, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin, input logic sub);
    logic [63:0] mask, lmask, beff, full, low;
    logic        ce, cout, cmsb;
    mask  = (64'd1 << w) - 64'd1;
    lmask = mask >> 1;
    beff  = (sub ? ~b : b) & mask;
    ce    = sub | cin;
    full  = (a & mask) + beff + 64'(ce);
    low   = (a & lmask) + (beff & lmask) + 64'(ce);
    cout  = full[w];
    cmsb  = low[w-1];
    return {29'd0, cout, cmsb ^ cout, ((full & mask) == 64'd0), full[31:0] & mask[31:0]};
  endfunction

  function automatic logic [63:0] pack32();
    return {29'd0, out_cout, out_ovf, out_zero, out_sum};
  endfunction

  function automatic logic [63:0] pack8();
    return {29'd0, s8_cout, s8_ovf, s8_zero, 24'd0, s8_sum};
  endfunction

  function automatic logic [63:0] pack16();
    return {29'd0, s16_cout, s16_ovf, s16_zero, 16'd0, s16_sum};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One isolated operation: no result before the STAGES-th edge, then exact values.
  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      check({tag, "_early"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"},   64'(out_sum),   64'(es));
    check({tag, "_cout"},  64'(out_cout),  64'(ec));
    check({tag, "_ovf"},   64'(out_ovf),   64'(eo));
    check({tag, "_zero"},  64'(out_zero),  64'(ez));
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with in_valid held high
    in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1111_1111;
    @(posedge clk); #1;
    check("rst_valid0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("rst_valid1", 64'(out_valid), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_sum",   64'(out_sum),  64'd0);
    check("rst_flags", 64'({out_cout, out_ovf, out_zero}), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", 64'(out_valid), 64'd0);
    end

    // Directed add/subtract vectors
    op_check("add_wrap",  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    op_check("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op_check("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    op_check("add_cin",   32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    op_check("sub_cin",   32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 1'b0);
    op_check("sub_eq",    32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    op_check("add_slice", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0, 1'b0);
    op_check("add_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    op_check("sub_mneg",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream of 8 random operations
    ngot = 0;
    for (int i = 0; i < 8 + LAT; i++) begin
      if (i < 8) begin
        in_a = $urandom; in_b = $urandom;
        in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        q32.push_back(model(W, 64'(in_a), 64'(in_b), in_cin, in_sub));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("stream_valid", 64'(out_valid), 64'((i >= LAT - 1) && (i < 8 + LAT - 1)));
      if (out_valid && q32.size() != 0) begin
        check("stream_data", pack32(), q32.pop_front());
        ngot++;
      end
    end
    check("stream_count", 64'(ngot), 64'd8);

    // Output stall holds everything and blocks the input
    for (int i = 0; i < 3; i++) begin
      in_a = $urandom; in_b = $urandom;
      in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      q32.push_back(model(W, 64'(in_a), 64'(in_b), in_cin, in_sub));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stall_first_valid", 64'(out_valid), 64'd1);
    exp0 = q32.pop_front();
    check("stall_first", pack32(), exp0);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid",    64'(out_valid), 64'd1);
      check("stall_hold",     pack32(), exp0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("drain_valid", 64'(out_valid), 64'd1);
      if (q32.size() != 0) check("drain_data", pack32(), q32.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("drain_empty", 64'(out_valid), 64'd0);
    end

    // Reset while operations are in flight
    for (int i = 0; i < 3; i++) begin
      in_a = $urandom; in_b = $urandom; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      check("flight_pre", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("flight_rst_valid", 64'(out_valid), 64'd0);
    check("flight_rst_sum",   64'(out_sum),   64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("flight_discard", 64'(out_valid), 64'd0);
    end
    op_check("post_flight", 32'h0000_1234, 32'h0000_0111, 1'b0, 1'b1, 32'h0000_1123, 1'b1, 1'b0, 1'b0);

    // Random sweep on the 8/4 and 16/16 geometries
    for (int i = 0; i < int'(NSW) + 3; i++) begin
      if (i < int'(NSW)) begin
        s8_a = 8'($urandom); s8_b = 8'($urandom);
        s8_cin = 1'($urandom_range(0, 1)); s8_sub = 1'($urandom_range(0, 1)); s8_valid = 1'b1;
        q8.push_back(model(8, 64'(s8_a), 64'(s8_b), s8_cin, s8_sub));
        s16_a = 16'($urandom); s16_b = 16'($urandom);
        s16_cin = 1'($urandom_range(0, 1)); s16_sub = 1'($urandom_range(0, 1)); s16_valid = 1'b1;
        q16.push_back(model(16, 64'(s16_a), 64'(s16_b), s16_cin, s16_sub));
      end else begin
        s8_valid = 1'b0; s16_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (s8_ovalid) begin
        check("sweep8_pending", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) check("sweep8", pack8(), q8.pop_front());
      end
      if (s16_ovalid) begin
        check("sweep16_pending", 64'(q16.size() != 0), 64'd1);
        if (q16.size() != 0) check("sweep16", pack16(), q16.pop_front());
      end
    end
    check("sweep8_drain",  64'(q8.size()),  64'd0);
    check("sweep16_drain", 64'(q16.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
